tests_stall_sink: RTL

Test-harness consumer for a valid/ready stream under injected back-pressure. It accepts a stream from the device under test and drives `ready_o` low whenever the external stall source asserts `stall_i`. While stalled, it checks that the producer keeps the beat pending and the data stable. It also keeps transfer and stall statistics and raises a sticky error code on any protocol violation or stall-induced starvation.

---
 rtl/tests_stall_sink.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tests_stall_sink.sv
// -----------------------------------------------------------------------------
// tests_stall_sink
//
// Test-harness consumer for a valid/ready stream under injected back-pressure.
// The block de-asserts ready whenever the external stall source requests it.
// While a beat is held off, it checks that the producer keeps that beat valid
// and keeps its payload stable. It also gathers transfer and stall statistics.
// Any protocol violation, or a beat that waits too long, moves the block into
// an absorbing error state with a sticky error code.
//
// Parameters
//   DATA_WIDTH  payload width
//   TIMEOUT     consecutive non-accepted cycles of a pending beat before a
//               timeout error (2..65535); the entry cycle counts as the first
//   CNT_WIDTH   width of the saturating statistics counters
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   stall_i      back-pressure request from the stall generator
//   valid_i      producer beat valid
//   data_i       producer payload
//   ready_o      !stall_i && not in error (combinational)
//   fire_o       valid_i && ready_o (combinational)
//   xfer_cnt_o   accepted beats, saturating
//   stall_cnt_o  cycles with valid_i && !ready_o outside the error state
//   max_run_o    longest completed wait of a pending beat, in cycles
//   err_o        sticky error flag
//   err_code_o   0 none, 1 valid withdrawn, 2 data changed, 3 timeout
// -----------------------------------------------------------------------------
module tests_stall_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  fire_o,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [15:0]           max_run_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [1:0]  CODE_NONE     = 2'd0;
    localparam logic [1:0]  CODE_WITHDRAW = 2'd1;
    localparam logic [1:0]  CODE_DATA     = 2'd2;
    localparam logic [1:0]  CODE_TIMEOUT  = 2'd3;
    // Wait count reached on the TIMEOUT-th non-accepted cycle.
    localparam logic [15:0] RUN_LIMIT     = 16'(TIMEOUT - 1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Larger of two 16-bit run lengths.
    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    state_t                 state_r;
    state_t                 next_state_s;
    logic [DATA_WIDTH-1:0]  hold_r;
    logic [DATA_WIDTH-1:0]  hold_nxt_s;
    logic [15:0]            run_r;
    logic [15:0]            run_nxt_s;
    logic [15:0]            max_r;
    logic [15:0]            max_nxt_s;
    logic [CNT_WIDTH-1:0]   xfer_r;
    logic [CNT_WIDTH-1:0]   xfer_nxt_s;
    logic [CNT_WIDTH-1:0]   stall_r;
    logic [CNT_WIDTH-1:0]   stall_nxt_s;
    logic                   err_r;
    logic                   err_nxt_s;
    logic [1:0]             code_r;
    logic [1:0]             code_nxt_s;
    logic                   ready_s;
    logic                   fire_s;
    logic                   blocked_s;

    // Handshake: ready depends only on the stall request and the error state.
    always_comb begin
        ready_s   = !stall_i && (state_r != ST_ERR);
        fire_s    = valid_i && ready_s;
        blocked_s = valid_i && !ready_s && (state_r != ST_ERR);
    end

    assign ready_o     = ready_s;
    assign fire_o      = fire_s;
    assign xfer_cnt_o  = xfer_r;
    assign stall_cnt_o = stall_r;
    assign max_run_o   = max_r;
    assign err_o       = err_r;
    assign err_code_o  = code_r;

    // Next-state, held-beat tracking and error capture.
    always_comb begin
        next_state_s = state_r;
        hold_nxt_s   = hold_r;
        run_nxt_s    = run_r;
        max_nxt_s    = max_r;
        err_nxt_s    = err_r;
        code_nxt_s   = code_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i && !ready_s) begin
                    // First stalled cycle of this beat counts as run 1.
                    next_state_s = ST_WAIT;
                    hold_nxt_s   = data_i;
                    run_nxt_s    = 16'd1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!valid_i) begin
                    next_state_s = ST_ERR;
                    err_nxt_s    = 1'b1;
                    code_nxt_s   = CODE_WITHDRAW;
                end else if (data_i != hold_r) begin
                    next_state_s = ST_ERR;
                    err_nxt_s    = 1'b1;
                    code_nxt_s   = CODE_DATA;
                end else if (ready_s) begin
                    // Acceptance wins over timeout on the same cycle.
                    next_state_s = ST_IDLE;
                    max_nxt_s    = max16(max_r, run_r);
                    run_nxt_s    = 16'd0;
                end else if (run_r == RUN_LIMIT) begin
                    next_state_s = ST_ERR;
                    err_nxt_s    = 1'b1;
                    code_nxt_s   = CODE_TIMEOUT;
                end else begin
                    run_nxt_s = run_r + 16'd1;
                end
            end
            ST_ERR: begin
                next_state_s = ST_ERR;
            end
            default: begin
                next_state_s = ST_IDLE;
                code_nxt_s   = CODE_NONE;
            end
        endcase
    end

    // Statistics counters; ready is low in the error state so both freeze there.
    always_comb begin
        xfer_nxt_s  = xfer_r;
        stall_nxt_s = stall_r;
        if (fire_s) begin
            xfer_nxt_s = sat_inc(xfer_r);
        end else begin
            xfer_nxt_s = xfer_r;
        end
        if (blocked_s) begin
            stall_nxt_s = sat_inc(stall_r);
        end else begin
            stall_nxt_s = stall_r;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            hold_r  <= {DATA_WIDTH{1'b0}};
            run_r   <= 16'd0;
            max_r   <= 16'd0;
            xfer_r  <= {CNT_WIDTH{1'b0}};
            stall_r <= {CNT_WIDTH{1'b0}};
            err_r   <= 1'b0;
            code_r  <= CODE_NONE;
        end else begin
            state_r <= next_state_s;
            hold_r  <= hold_nxt_s;
            run_r   <= run_nxt_s;
            max_r   <= max_nxt_s;
            xfer_r  <= xfer_nxt_s;
            stall_r <= stall_nxt_s;
            err_r   <= err_nxt_s;
            code_r  <= code_nxt_s;
        end
    end

    tests_stall_sink_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .fire_o     (fire_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

endmodule

// -----------------------------------------------------------------------------
// tests_stall_sink_chk
//
// Property checker for tests_stall_sink's externally visible behaviour.
// Ports: clk, rst, and the sink's handshake and error outputs (inputs here).
// -----------------------------------------------------------------------------
module tests_stall_sink_chk (
    input logic       clk,
    input logic       rst,
    input logic       stall_i,
    input logic       valid_i,
    input logic       ready_o,
    input logic       fire_o,
    input logic       err_o,
    input logic [1:0] err_code_o
);

    // Error state never signals ready.
    a_err_blocks: assert property (@(posedge clk) disable iff (rst) err_o |-> !ready_o);

    // Error flag and a non-zero code always travel together.
    a_code_flag: assert property (@(posedge clk) disable iff (rst) err_o == (err_code_o != 2'd0));

    // Error flag and code are sticky until reset.
    a_sticky: assert property (@(posedge clk) disable iff (rst)
        err_o |=> (err_o && $stable(err_code_o)));

    // A stall request always blocks the handshake.
    a_stall_blocks: assert property (@(posedge clk) stall_i |-> !ready_o);

    // Fire is exactly the handshake.
    a_fire: assert property (@(posedge clk) fire_o == (valid_i && ready_o));

endmodule
